// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle over WIDTH cycles,
// with a start/busy/done handshake and registered, held results.
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;       // dividend bits out at MSB, quotient bits in at LSB
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_q;

    always_comb begin
        shifted  = {rem_q[WIDTH-1:0], dq_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        step_rem = trial[WIDTH] ? shifted : trial;
        step_q   = {dq_q[WIDTH-2:0], ~trial[WIDTH]};

        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle, StFin: begin
                // The done cycle accepts a new start exactly like idle.
                if (start) begin
                    dq_d    = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    zero_d  = (divisor == '0);
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (zero_q) begin
                    // Divide-by-zero skips iteration; dq_q still holds the dividend.
                    quot_d  = '1;
                    remo_d  = dq_q;
                    dbz_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    rem_d = step_rem;
                    dq_d  = step_q;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LastCnt) begin
                        quot_d  = step_q;
                        remo_d  = step_rem[WIDTH-1:0];
                        dbz_d   = 1'b0;
                        state_d = StFin;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StFin);
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8) against an arithmetic reference model.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int vectors = 0;
    int errors  = 0;

    seq_divider #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Stimulus only: issue one operation, return edges-to-done and busy cycle count.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int k, output int bcnt);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
        k = 0; bcnt = 0;
        while (!done && k < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int k, bcnt;
        do_op(8'd200, 8'd7, k, bcnt);
        vectors++;
        if (bcnt !== 8) begin
            errors++; $display("FAIL basic_busy_cycles: got %0d want 8", bcnt);
        end
        vectors++;
        if (k !== 8) begin
            errors++; $display("FAIL basic_latency: got %0d want 8", k);
        end
        vectors++;
        if ({quotient, remainder, div_by_zero} !== {8'd28, 8'd4, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%b want q=28 r=4 dbz=0",
                     quotient, remainder, div_by_zero);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL basic_busy_in_done: got %b want 0", busy);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL basic_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_corners();
        logic [7:0] ta [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
        logic [7:0] tb [4] = '{8'd1, 8'd9, 8'd255, 8'd3};
        int k, bcnt;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], k, bcnt);
            vectors++;
            if ({quotient, remainder, div_by_zero} !== {ta[i] / tb[i], ta[i] % tb[i], 1'b0}
                || k !== 8) begin
                errors++;
                $display("FAIL corner_%0d_%0d: got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d",
                         ta[i], tb[i], quotient, remainder, div_by_zero, k,
                         ta[i] / tb[i], ta[i] % tb[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int k, bcnt;
        do_op(8'd100, 8'd0, k, bcnt);
        vectors++;
        if (k !== 1 || bcnt !== 1) begin
            errors++; $display("FAIL dbz_timing: got lat=%0d busy=%0d want 1 1", k, bcnt);
        end
        vectors++;
        if ({quotient, remainder, div_by_zero} !== {8'd255, 8'd100, 1'b1}) begin
            errors++;
            $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b want q=255 r=100 dbz=1",
                     quotient, remainder, div_by_zero);
        end
        do_op(8'd10, 8'd3, k, bcnt);
        vectors++;
        if ({quotient, remainder, div_by_zero} !== {8'd3, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL dbz_clear: got q=%0d r=%0d dbz=%b want q=3 r=1 dbz=0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        logic [7:0] q = '0, r = '0;
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) begin start = 1'b1; dividend = 8'd50; divisor = 8'd3; end
            if (k == 4) start = 1'b0;
            if (done) begin ndone++; q = quotient; r = remainder; end
            @(negedge clk);
        end
        vectors++;
        if (ndone !== 1) begin
            errors++; $display("FAIL ignore_done_count: got %0d want 1", ndone);
        end
        vectors++;
        if ({q, r} !== {8'd28, 8'd4}) begin
            errors++; $display("FAIL ignore_result: got q=%0d r=%0d want q=28 r=4", q, r);
        end
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        int k, bcnt;
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        vectors++;
        if (ndone !== 0) begin
            errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", ndone);
        end
        do_op(8'd77, 8'd5, k, bcnt);
        vectors++;
        if ({quotient, remainder, div_by_zero} !== {8'd15, 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL abort_recover: got q=%0d r=%0d dbz=%b want q=15 r=2 dbz=0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        int cyc = 0, n = 0, want_gap;
        a = 8'($urandom);
        b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        while (n < 2000) begin
            @(negedge clk);
            cyc++;
            vectors++;
            if (busy && done) begin
                errors++; $display("FAIL b2b_busy_and_done: op %0d both high", n);
            end
            if (done) begin
                want_gap = (b == 0) ? 2 : 9;
                vectors++;
                if (cyc !== want_gap) begin
                    errors++; $display("FAIL b2b_spacing: op %0d got %0d want %0d", n, cyc, want_gap);
                end
                vectors++;
                if (b == 0) begin
                    if ({quotient, remainder, div_by_zero} !== {8'd255, a, 1'b1}) begin
                        errors++;
                        $display("FAIL b2b_dbz %0d/0: got q=%0d r=%0d dbz=%b want 255 %0d 1",
                                 a, quotient, remainder, div_by_zero, a);
                    end
                end else begin
                    if ({quotient, remainder, div_by_zero} !== {a / b, a % b, 1'b0}) begin
                        errors++;
                        $display("FAIL b2b_result %0d/%0d: got q=%0d r=%0d want q=%0d r=%0d",
                                 a, b, quotient, remainder, a / b, a % b);
                    end
                    vectors++;
                    if (int'(quotient) * int'(b) + int'(remainder) != int'(a) || remainder >= b) begin
                        errors++;
                        $display("FAIL b2b_invariant %0d/%0d: got q=%0d r=%0d", a, b,
                                 quotient, remainder);
                    end
                end
                a = 8'($urandom);
                b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                dividend = a; divisor = b;
                cyc = 0;
                n++;
            end else if (cyc > 40) begin
                vectors++; errors++;
                $display("FAIL b2b_timeout: op %0d got no done after %0d cycles want 9", n, cyc);
                break;
            end
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
